// File: rtl/vfa_pkg.sv
// ---------------------------------------------------------------------------
// vfa_pkg : shared types and default geometry for video_frame_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vfa_pkg;

  localparam int VFA_DATA_W         = 96;
  localparam int VFA_LINES          = 64;
  localparam int VFA_BEATS_PER_LINE = 16;
  localparam int VFA_CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } vfa_state_t;

  function automatic logic [VFA_CNT_W-1:0] vfa_sat_add(
    input logic [VFA_CNT_W-1:0] a,
    input logic [1:0]           b
  );
    logic [VFA_CNT_W:0] sum;
    sum = {1'b0, a} + {{(VFA_CNT_W-1){1'b0}}, b};
    return sum[VFA_CNT_W] ? {VFA_CNT_W{1'b1}} : sum[VFA_CNT_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/video_frame_arbiter_if.sv
// ---------------------------------------------------------------------------
// video_frame_arbiter_if : AXI4-Stream video channel (tdata/tvalid/tuser/tlast/tready)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface video_frame_arbiter_if #(
  parameter int DATA_W = 96
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tuser;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tuser, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tuser, input  tlast, output tready);

endinterface

`default_nettype wire

// File: rtl/vfa_geom_check.sv
// ---------------------------------------------------------------------------
// vfa_geom_check : per-line beat counter with sticky geometry error flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vfa_geom_check
  import vfa_pkg::*;
#(
  parameter int BEATS_PER_LINE = VFA_BEATS_PER_LINE
) (
  input  wire logic i_clk,
  input  wire logic i_rst_n,
  input  wire logic i_accept,
  input  wire logic i_tuser,
  input  wire logic i_tlast,
  input  wire logic i_frame_done,
  output logic      o_geom_err
);

  localparam int BEAT_W = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

  logic [BEAT_W-1:0] r_beat;
  logic              r_first;
  logic              r_err;
  logic              w_at_last;
  logic              w_bad;

  assign w_at_last = (r_beat == LAST_BEAT);
  assign w_bad     = i_accept & ((i_tlast & ~w_at_last) |
                                 (~i_tlast & w_at_last) |
                                 (i_tuser & ~r_first));

  // A line that overruns its last beat restarts counting so later lines still check.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat  <= '0;
      r_first <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      if (w_bad) begin
        r_err <= 1'b1;
      end
      if (i_accept) begin
        r_beat  <= (i_tlast | w_at_last) ? '0 : r_beat + 1'b1;
        r_first <= i_frame_done;
      end
    end
  end

  assign o_geom_err = r_err;

endmodule

`default_nettype wire

// File: rtl/video_frame_arbiter.sv
// ---------------------------------------------------------------------------
// video_frame_arbiter : two-source frame-granular video stream arbiter
// Optional geometry checker enabled by macro VFA_GEOM_CHECK_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module video_frame_arbiter
  import vfa_pkg::*;
#(
  parameter int DATA_W         = VFA_DATA_W,
  parameter int LINES          = VFA_LINES,
  parameter int BEATS_PER_LINE = VFA_BEATS_PER_LINE
) (
  input  wire logic               s_axis_video_aclk,
  input  wire logic               s_axis_video_aresetn,
  video_frame_arbiter_if.slave    S0,
  video_frame_arbiter_if.slave    S1,
  video_frame_arbiter_if.master   VIDEO_OUT,
  output logic [1:0]              grant,
  output logic [VFA_CNT_W-1:0]    frame_cnt,
  output logic [VFA_CNT_W-1:0]    drop_cnt,
  output logic                    geom_err
);

  localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

  vfa_state_t           r_state;
  vfa_state_t           w_state_next;
  logic                 r_last_s1;
  logic [LINE_W-1:0]    r_line_cnt;
  logic [VFA_CNT_W-1:0] r_frame_cnt;
  logic [VFA_CNT_W-1:0] r_drop_cnt;

  logic [DATA_W-1:0]    w_sel_data;
  logic                 w_sel_valid;
  logic                 w_sel_user;
  logic                 w_sel_last;
  logic                 w_accept;
  logic                 w_frame_done;
  logic                 w_req0;
  logic                 w_req1;
  logic                 w_drop0;
  logic                 w_drop1;

  // Output mux: zero-latency passthrough of the granted source, all zeros when idle.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_user  = 1'b0;
    w_sel_last  = 1'b0;
    case (r_state)
      GRANT0: begin
        w_sel_data  = S0.tdata;
        w_sel_valid = S0.tvalid;
        w_sel_user  = S0.tuser;
        w_sel_last  = S0.tlast;
      end
      GRANT1: begin
        w_sel_data  = S1.tdata;
        w_sel_valid = S1.tvalid;
        w_sel_user  = S1.tuser;
        w_sel_last  = S1.tlast;
      end
      default: ;
    endcase
  end

  assign VIDEO_OUT.tdata  = w_sel_data;
  assign VIDEO_OUT.tvalid = w_sel_valid;
  assign VIDEO_OUT.tuser  = w_sel_user;
  assign VIDEO_OUT.tlast  = w_sel_last;

  assign w_accept     = w_sel_valid & VIDEO_OUT.tready;
  assign w_frame_done = w_accept & w_sel_last & (r_line_cnt == LAST_LINE);
  assign w_req0       = S0.tvalid & S0.tuser;
  assign w_req1       = S1.tvalid & S1.tuser;

  always_comb begin
    w_state_next = r_state;
    grant        = 2'b00;
    S0.tready    = 1'b0;
    S1.tready    = 1'b0;
    w_drop0      = 1'b0;
    w_drop1      = 1'b0;
    case (r_state)
      IDLE: begin
        // Pre-SOF beats are swallowed; gated by reset so tready stays low while held.
        w_drop0   = S0.tvalid & ~S0.tuser & s_axis_video_aresetn;
        w_drop1   = S1.tvalid & ~S1.tuser & s_axis_video_aresetn;
        S0.tready = w_drop0;
        S1.tready = w_drop1;
        if (w_req0 && w_req1) begin
          w_state_next = r_last_s1 ? GRANT0 : GRANT1;
        end else if (w_req0) begin
          w_state_next = GRANT0;
        end else if (w_req1) begin
          w_state_next = GRANT1;
        end
      end
      GRANT0: begin
        grant     = 2'b01;
        S0.tready = VIDEO_OUT.tready;
        if (w_frame_done) begin
          w_state_next = IDLE;
        end
      end
      GRANT1: begin
        grant     = 2'b10;
        S1.tready = VIDEO_OUT.tready;
        if (w_frame_done) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_video_aclk or negedge s_axis_video_aresetn) begin
    if (!s_axis_video_aresetn) begin
      r_state     <= IDLE;
      r_last_s1   <= 1'b1;
      r_line_cnt  <= '0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept && w_sel_last) begin
        r_line_cnt <= w_frame_done ? '0 : r_line_cnt + 1'b1;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
        r_last_s1   <= (r_state == GRANT1);
      end
      if (w_drop0 || w_drop1) begin
        r_drop_cnt <= vfa_sat_add(r_drop_cnt, {1'b0, w_drop0} + {1'b0, w_drop1});
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;

`ifdef VFA_GEOM_CHECK_EN
  vfa_geom_check #(
    .BEATS_PER_LINE (BEATS_PER_LINE)
  ) u_geom_check (
    .i_clk        (s_axis_video_aclk),
    .i_rst_n      (s_axis_video_aresetn),
    .i_accept     (w_accept),
    .i_tuser      (w_sel_user),
    .i_tlast      (w_sel_last),
    .i_frame_done (w_frame_done),
    .o_geom_err   (geom_err)
  );
`else
  assign geom_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/video_frame_arbiter.md
VIDEO_FRAME_ARBITER -- requirements
Module: video_frame_arbiter

Interface
REQ-001 Parameter DATA_W, default 96, stream beat width (4 pixels x 24-bit RGB).
REQ-002 Parameter LINES, default 64, lines per frame.
REQ-003 Parameter BEATS_PER_LINE, default 16, beats per line (64 pixels / 4).
REQ-004 One clock; reset is asynchronous and active-low. Ports are s_axis_video_aclk and s_axis_video_aresetn.
REQ-005 s_axis_video_aclk  in  1  clock for all logic.
REQ-006 s_axis_video_aresetn  in  1  asynchronous active-low reset.
REQ-007 S0_tdata/S1_tdata  in  DATA_W  source pixel data.
REQ-008 S0_tvalid/S1_tvalid, S0_tuser/S1_tuser (SOF), S0_tlast/S1_tlast (EOL)  in  1 each.
REQ-009 S0_tready/S1_tready  out  1 each  per-source ready.
REQ-010 VIDEO_OUT_tdata  out  DATA_W; VIDEO_OUT_tvalid, VIDEO_OUT_tuser, VIDEO_OUT_tlast  out  1 each.
REQ-011 VIDEO_OUT_tready  in  1  sink ready.
REQ-012 grant  out  2  one-hot owner (00 = none).
REQ-013 frame_cnt  out  16  frames completed on output, wraps at 0xFFFF->0.
REQ-014 drop_cnt  out  16  pre-SOF beats discarded, saturates at 0xFFFF.
REQ-015 geom_err  out  1  sticky geometry error.

Function
REQ-016 FSM states IDLE, GRANT0, GRANT1; grant = 00/01/10 respectively.
REQ-017 IDLE: a source with tvalid=1 and tuser=1 is a request. One request -> grant that source. Two requests -> grant the source not granted last. After reset, S0 wins a tie.
REQ-018 IDLE: a source with tvalid=1 and tuser=0 sees tready=1; the beat is discarded and drop_cnt increments (once per beat, two sources same cycle -> +2).
REQ-019 Transition IDLE->GRANTn takes 1 cycle. The SOF beat is not consumed in IDLE (tready=0 for a requesting source).
REQ-020 GRANTn: VIDEO_OUT_{tdata,tvalid,tuser,tlast} = Sn signals combinationally; Sn_tready = VIDEO_OUT_tready; the other source tready=0; zero-latency passthrough.
REQ-021 A beat is accepted when VIDEO_OUT_tvalid && VIDEO_OUT_tready; tlast accepts are counted in line_cnt.
REQ-022 On acceptance of the tlast beat with line_cnt == LINES-1: return to IDLE next cycle, increment frame_cnt, clear line_cnt, record the last grant.
REQ-023 IDLE: VIDEO_OUT_tvalid=0, tuser=0, tlast=0, tdata=0.
REQ-024 Sink backpressure (tready=0) holds all counters; no beat is lost or duplicated.
REQ-025 A tuser beat inside a granted frame passes through unchanged and does not end the grant.

Reset
REQ-026 Asynchronous assert: state=IDLE, grant=00, last-grant=S1 (S0 priority), line_cnt=0, frame_cnt=0, drop_cnt=0, geom_err=0, all tready=0, all VIDEO_OUT outputs 0.
REQ-027 Reset mid-frame aborts the frame with no completion count. The first post-release cycle is IDLE.

Configuration
REQ-028 Macro VFA_GEOM_CHECK_EN defined: a beat counter checks each line. geom_err sets when tlast arrives at beat != BEATS_PER_LINE-1, when beat BEATS_PER_LINE-1 has tlast=0, or when tuser=1 at any beat other than the first of the frame. The flag clears only on reset. Passthrough is unaffected.
REQ-029 Macro VFA_GEOM_CHECK_EN undefined: no check logic; geom_err tied 0.

Structure
REQ-030 Shared package vfa_pkg: state enum (IDLE/GRANT0/GRANT1), default LINES/BEATS_PER_LINE/DATA_W constants, and the counter width (16).
REQ-031 One sub-module, vfa_geom_check (beat/line counter plus error flag), instantiated only under VFA_GEOM_CHECK_EN.

Verification
REQ-032 Only S0 sends a 64x16-beat frame with VIDEO_OUT_tready=1 -> grant=01 for 1024 beats, output data identical, frame_cnt=1, then grant=00.
REQ-033 S0 and S1 both present SOF in the same cycle after reset -> S0 granted first. S1 is granted after S0's 64th tlast, then S0 again. frame_cnt=3 after three frames.
REQ-034 S1 sends 5 beats with tuser=0 while IDLE -> all 5 see S1_tready=1 and drop_cnt=5; nothing appears on VIDEO_OUT.
REQ-035 Random VIDEO_OUT_tready (50%) during a frame -> output beat sequence equals input sequence exactly; the grant ends only after the 64th tlast.
REQ-036 Reset asserted at line 30 of a granted frame -> all outputs 0 immediately, frame_cnt=0; the next SOF is granted normally.
REQ-037 With VFA_GEOM_CHECK_EN, tlast sent on beat 14 of line 3 -> geom_err=1 and stays 1. Without the macro, the same stimulus -> geom_err=0.
